// File: rtl/stimulus_ctrl_if.sv
// Bus between the reaction-tester front end and StateMachine: state/turn inputs,
// handshake flags, measured time and current player.
interface stimulus_ctrl_if;
    logic [2:0] machine_state;
    logic [2:0] test_turn_A;
    logic [2:0] test_turn_B;
    logic [6:0] signals;
    logic [9:0] react_time;
    logic       cur_player;

    modport master (
        input  machine_state, test_turn_A, test_turn_B,
        output signals, react_time, cur_player
    );

    modport slave (
        output machine_state, test_turn_A, test_turn_B,
        input  signals, react_time, cur_player
    );
endinterface

// File: rtl/stimulus_ctrl.sv
// Reaction-tester front end: key debouncing, random start delay, millisecond reaction
// timing and per-state handshake flags toward StateMachine.
module stimulus_ctrl #(
    parameter int unsigned MS_DIV       = 12000,
    parameter int unsigned DEBOUNCE_MS  = 20,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned OVERFLOW_MS  = 999
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   key_action_n,
    input  logic                   key_react_n,
    stimulus_ctrl_if.master        bus
);

    localparam int unsigned TW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int unsigned DW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS + 1) : 1;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StWait    = 3'd1;
    localparam logic [2:0] StClrCnt1 = 3'd2;
    localparam logic [2:0] StStart   = 3'd3;
    localparam logic [2:0] StStorage = 3'd4;
    localparam logic [2:0] StClrCnt2 = 3'd5;
    localparam logic [2:0] StAverage = 3'd6;

    // signals bit positions
    localparam int unsigned FAction  = 6;
    localparam int unsigned FReact   = 5;
    localparam int unsigned FAverage = 4;
    localparam int unsigned FCompare = 3;
    localparam int unsigned FStart   = 2;
    localparam int unsigned FOvf     = 1;
    localparam int unsigned FCleared = 0;

    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic                  ms_tick, clr_tick;
    logic [1:0]            sync1_q, sync2_q, level, db_q, press;
    logic [1:0][DW-1:0]    db_cnt_q;
    logic [15:0]           lfsr_q;
    logic [2:0]            prev_state_q;
    logic                  entry;
    logic [6:0]            flags_q, flags_d;
    logic [11:0]           delay_q, delay_d;
    logic [9:0]            react_cnt_q, react_cnt_d;
    logic [9:0]            react_time_q, react_time_d;
    logic                  cur_player_q, cur_player_d;
    logic [2:0]            turn_cur, turn_other;

    assign ms_tick    = (tick_cnt_q == TW'(MS_DIV - 1));
    assign tick_cnt_d = (clr_tick || ms_tick) ? '0 : tick_cnt_q + 1'b1;

    // Index 0 = action key, index 1 = react key; keys are active-low.
    assign level = ~sync2_q;
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            press[i] = ms_tick && (level[i] != db_q[i]) && level[i] &&
                       (db_cnt_q[i] == DW'(DEBOUNCE_MS - 1));
        end
    end

    assign entry      = (bus.machine_state != prev_state_q);
    assign turn_cur   = cur_player_q ? bus.test_turn_A : bus.test_turn_B;
    assign turn_other = cur_player_q ? bus.test_turn_B : bus.test_turn_A;

    always_comb begin
        flags_d      = entry ? '0 : flags_q;
        delay_d      = delay_q;
        react_cnt_d  = react_cnt_q;
        react_time_d = react_time_q;
        cur_player_d = cur_player_q;
        clr_tick     = 1'b0;
        case (bus.machine_state)
            StIdle: begin
                if (press[0]) flags_d[FAction] = 1'b1;
            end
            StWait: begin
                if (entry) begin
                    delay_d = 12'(MIN_DELAY_MS) + {1'b0, lfsr_q[10:0]};
                end else if (delay_q == '0) begin
                    flags_d[FStart] = 1'b1;
                end else if (ms_tick) begin
                    delay_d = delay_q - 12'd1;
                end
            end
            StClrCnt1: begin
                flags_d[FCleared] = 1'b1;
                if (entry) begin
                    react_cnt_d  = '0;
                    react_time_d = '0;
                    clr_tick     = 1'b1;
                end
            end
            StStart: begin
                if (ms_tick && react_cnt_q != 10'(OVERFLOW_MS)) react_cnt_d = react_cnt_q + 10'd1;
                // Overflow wins over a press landing in the same cycle.
                if (entry || !flags_q[FReact]) begin
                    if (react_cnt_q == 10'(OVERFLOW_MS)) begin
                        flags_d[FReact] = 1'b1;
                        flags_d[FOvf]   = 1'b1;
                        react_time_d    = 10'(OVERFLOW_MS);
                    end else if (press[1]) begin
                        flags_d[FReact] = 1'b1;
                        react_time_d    = react_cnt_q;
                    end
                end
            end
            StStorage: begin
                if (turn_cur == 3'd7) flags_d[FAverage] = 1'b1;
                else if (press[0])    flags_d[FAction]  = 1'b1;
            end
            StClrCnt2: begin
                flags_d[FCleared] = 1'b1;
                if (entry) begin
                    react_cnt_d = '0;
                    clr_tick    = 1'b1;
                end
            end
            StAverage: begin
                if (bus.test_turn_A == 3'd7 && bus.test_turn_B == 3'd7) begin
                    flags_d[FCompare] = 1'b1;
                end else if (turn_other != 3'd7 && press[0] && (entry || !flags_q[FAction])) begin
                    flags_d[FAction] = 1'b1;
                    cur_player_d     = ~cur_player_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_cnt_q   <= '0;
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            db_q         <= '0;
            db_cnt_q     <= '0;
            lfsr_q       <= 16'hACE1;
            prev_state_q <= StIdle;
            flags_q      <= '0;
            delay_q      <= '0;
            react_cnt_q  <= '0;
            react_time_q <= '0;
            cur_player_q <= 1'b1;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            sync1_q      <= {key_react_n, key_action_n};
            sync2_q      <= sync1_q;
            lfsr_q       <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            prev_state_q <= bus.machine_state;
            flags_q      <= flags_d;
            delay_q      <= delay_d;
            react_cnt_q  <= react_cnt_d;
            react_time_q <= react_time_d;
            cur_player_q <= cur_player_d;
            for (int i = 0; i < 2; i++) begin
                if (level[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (ms_tick) begin
                    if (db_cnt_q[i] == DW'(DEBOUNCE_MS - 1)) begin
                        db_q[i]     <= level[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Flags drop in the entry cycle itself, before the register catches up.
    assign bus.signals    = entry ? '0 : flags_q;
    assign bus.react_time = react_time_q;
    assign bus.cur_player = cur_player_q;

endmodule

// File: doc/stimulus_ctrl.md
Name: stimulus_ctrl

Overview:
- Physical front end of the reaction-time tester. It drives the 7-bit signals bus, react_time and cur_player into StateMachine, and consumes StateMachine's machine_state and test_turn outputs.
- Converts two raw push-buttons into debounced press events, generates the random pre-start delay and times the reaction in milliseconds.
- Raises each handshake flag only in the machine state that consumes it.

Parameters:
- MS_DIV, 12000, clk cycles per 1 ms tick (12 MHz clock).
- DEBOUNCE_MS, 20, ms a key must stay stable before its new level is accepted.
- MIN_DELAY_MS, 1000, minimum WAIT-to-start delay.
- OVERFLOW_MS, 999, reaction-time ceiling; also the saturated react_time value.

Ports:
- clk  in  1  system clock, 12 MHz.
- rstn  in  1  asynchronous active-low reset.
- key_action_n  in  1  raw action button, active-low, asynchronous.
- key_react_n  in  1  raw react button, active-low, asynchronous.
- machine_state  in  3  StateMachine state: IDLE=0 WAIT=1 CLR_CNT1=2 START=3 STORAGE=4 CLR_CNT2=5 AVERAGE=6 COMPARE=7.
- test_turn_A  in  3  completed trials, player A.
- test_turn_B  in  3  completed trials, player B.
- signals  out  7  {action, react, average, compare, start, overflow, cleared}; bit 6 = action.
- react_time  out  10  measured reaction in ms for the current trial.
- cur_player  out  1  PLAYER_A=1, PLAYER_B=0.

Behaviour:
- Reset (async, rstn=0):
  - signals=0, react_time=0, cur_player=1 (PLAYER_A).
  - Tick counter, debouncers, delay counter and state tracker all cleared.
  - LFSR loaded with 16'hACE1, never zero.
- Timebase: free-running counter 0..MS_DIV-1; ms_tick is a 1-cycle pulse when it wraps.
- Key path, per key:
  - 2-FF synchronizer, then invert.
  - A level change is accepted after DEBOUNCE_MS consecutive ticks at the new level.
  - Accepted 0→1 gives press = 1-cycle pulse. Release produces nothing.
  - A glitch shorter than DEBOUNCE_MS never yields a press.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clk.
- State tracking:
  - prev_state is registered; entry = (machine_state != prev_state).
  - On entry, all signal flags are cleared the same cycle.
  - Each flag, once set, holds until the next entry.
- Per state:
  - IDLE: action press → action=1.
  - WAIT:
    - On entry, load delay = MIN_DELAY_MS + LFSR[10:0] (1000..3047 ms).
    - Decrement on ms_tick; at 0 → start=1.
    - React presses in WAIT are ignored (no false-start penalty).
  - CLR_CNT1: on entry, clear react counter and tick counter; cleared=1 on the next cycle.
  - START:
    - React counter increments on ms_tick.
    - React press → react=1; react_time = counter, frozen.
    - Counter reaches OVERFLOW_MS with no press → react=1, overflow=1, react_time=OVERFLOW_MS.
    - Press and overflow in the same cycle → treated as overflow.
  - STORAGE:
    - If test_turn of cur_player == 7 → average=1 one cycle after entry.
    - Otherwise wait for action press → action=1.
  - CLR_CNT2: clear counters on entry; cleared=1 on the next cycle.
  - AVERAGE:
    - If test_turn_A == 7 and test_turn_B == 7 → compare=1.
    - Else if the other player's test_turn != 7: wait for action press, then toggle cur_player in the same cycle action=1 is set.
    - Else hold all flags at 0.
  - COMPARE: all flags 0; presses ignored. Only rstn restarts the game.
- react_time holds its value from the react assertion through STORAGE/AVERAGE, until the next CLR_CNT1 entry.
- Presses arriving in a state that does not consume them are discarded, never queued.
- Reset mid-operation (any state): outputs return to reset values within the asserting edge; no partial trial is retained.
- Width rules:
  - React counter is 10 bits and saturates at OVERFLOW_MS (never wraps).
  - Delay counter is 12 bits.

Test Plan (MS_DIV=12, DEBOUNCE_MS=2 for simulation):
- Reset: rstn=0 at any state → signals=7'b0, react_time=0, cur_player=1; after release, LFSR is non-zero.
- Debounce: IDLE, key_action_n low for 1 ms then high → no action. Low for 3 ms → signals[6]=1 held until machine_state leaves IDLE.
- Delay/start:
  - Hold machine_state=WAIT from entry with LFSR forced to 0 → start asserts after 1000 ms ±1 tick.
  - React press during WAIT → no react flag.
- Timed trial:
  - CLR_CNT1 → cleared=1 one cycle after entry.
  - START, react press 300 ms after entry → react=1, react_time=300±1, stable through STORAGE.
- Overflow: START with no press → at 999 ms react=1, overflow=1, react_time=999; press 2 ms later changes nothing.
- Player switch/compare:
  - AVERAGE with test_turn_A=7, test_turn_B=3, action press → action=1 and cur_player 1→0.
  - AVERAGE with both turns=7 → compare=1, action not set.
  - Reset asserted mid-START → counters and flags zero.
